// File: rtl/mt_fetch_pkg.sv
// rtl/mt_fetch_pkg.sv - shared constants and types for the multithreaded fetch unit
package mt_fetch_pkg;

    // Upper bound on hardware thread contexts a fetch unit may be built with.
    localparam int MAX_THREADS = 8;

    // Thread id wide enough for the largest supported configuration.
    localparam int TID_W = $clog2(MAX_THREADS);
    typedef logic [TID_W-1:0] tid_t;

    // Sequential fetch advances by one 32-bit instruction.
    localparam int PC_INC = 4;

endpackage

// File: rtl/mt_fetch_unit_rr_arbiter.sv
// rtl/mt_fetch_unit_rr_arbiter.sv - combinational round-robin thread picker
module rr_thread_arbiter #(
    parameter int N  = 2,
    parameter int TW = 1
) (
    input  logic [N-1:0]  mask,
    input  logic [TW-1:0] last_grant,
    output logic [TW-1:0] next_grant,
    output logic          any_valid
);

    logic [TW-1:0] cand;

    // Scan last+1, last+2, ... wrapping, with last itself checked at the end;
    // with nothing enabled the previous grant is kept.
    always_comb begin
        next_grant = last_grant;
        any_valid  = 1'b0;
        cand       = '0;
        for (int i = 1; i <= N; i++) begin
            // N is a power of two, so truncating to TW bits is the wrap.
            cand = (N == 1) ? '0 : TW'(int'(last_grant) + i);
            if (!any_valid && mask[cand]) begin
                next_grant = cand;
                any_valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mt_fetch_unit.sv
// rtl/mt_fetch_unit.sv - per-thread PC file with round-robin fetch selection (MT_FETCH_PERF_EN adds fetch counters)
module mt_fetch_unit
    import mt_fetch_pkg::*;
#(
    parameter int          NUM_THREADS  = 2,
    parameter int          ADDR_WIDTH   = 26,
    parameter int unsigned RESET_PC     = 0,
    parameter int unsigned RESET_STRIDE = 0,
    localparam int         TW           = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_stall,
    input  logic [NUM_THREADS-1:0] i_thread_en,
    input  logic                   i_redirect_valid,
    input  logic [TW-1:0]          i_redirect_tid,
    input  logic [ADDR_WIDTH-1:0]  i_redirect_pc,
    input  logic                   i_pred_valid,
    input  logic                   i_pred_taken,
    input  logic [ADDR_WIDTH-1:0]  i_pred_target,
    output logic                   o_valid,
    output logic [ADDR_WIDTH-1:0]  o_pc_current,
    output logic [TW-1:0]          o_tid_current,
    output logic [ADDR_WIDTH-1:0]  o_pc_next,
    output logic [TW-1:0]          o_tid_next
`ifdef MT_FETCH_PERF_EN
    ,
    output logic [NUM_THREADS*32-1:0] o_fetch_cnt
`endif
);

    logic [ADDR_WIDTH-1:0] pc_q [NUM_THREADS];
    logic [ADDR_WIDTH-1:0] pc_d [NUM_THREADS];
    logic [TW-1:0]         tid_q;
    logic [TW-1:0]         tid_d;
    logic                  valid_q;
    logic                  valid_d;
    logic [TW-1:0]         rr_grant;
    logic                  rr_any;

    rr_thread_arbiter #(
        .N  (NUM_THREADS),
        .TW (TW)
    ) u_rr_thread_arbiter (
        .mask       (i_thread_en),
        .last_grant (tid_q),
        .next_grant (rr_grant),
        .any_valid  (rr_any)
    );

    // Post-update PC of every thread: redirect wins, then prediction and
    // sequential advance for the current thread only; stall freezes all.
    always_comb begin
        for (int t = 0; t < NUM_THREADS; t++) begin
            pc_d[t] = pc_q[t];
            if (!i_stall) begin
                if (i_redirect_valid && (i_redirect_tid == TW'(t))) begin
                    pc_d[t] = i_redirect_pc;
                end else if (tid_q == TW'(t)) begin
                    if (i_pred_valid && i_pred_taken) begin
                        pc_d[t] = i_pred_target;
                    end else if (valid_q) begin
                        pc_d[t] = pc_q[t] + ADDR_WIDTH'(PC_INC);
                    end
                end
            end
        end
    end

    // Next thread selection; an idle mask keeps the current thread but drops valid.
    always_comb begin
        tid_d   = i_stall ? tid_q   : rr_grant;
        valid_d = i_stall ? valid_q : rr_any;
    end

    assign o_valid       = valid_q;
    assign o_tid_current = tid_q;
    assign o_pc_current  = pc_q[tid_q];
    assign o_tid_next    = tid_d;
    assign o_pc_next     = pc_d[tid_d];

    // PC file and fetch slot registers; reset overrides every other request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                pc_q[t] <= ADDR_WIDTH'(RESET_PC + RESET_STRIDE * unsigned'(t));
            end
            tid_q   <= '0;
            valid_q <= 1'b1;
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                pc_q[t] <= pc_d[t];
            end
            tid_q   <= tid_d;
            valid_q <= valid_d;
        end
    end

`ifdef MT_FETCH_PERF_EN
    logic [31:0] fetch_cnt_q [NUM_THREADS];

    // Count real, unstalled fetches per thread; wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                fetch_cnt_q[t] <= '0;
            end
        end else if (valid_q && !i_stall) begin
            fetch_cnt_q[tid_q] <= fetch_cnt_q[tid_q] + 32'd1;
        end
    end

    // Flatten the counters onto the output bus, thread 0 in the low word.
    always_comb begin
        o_fetch_cnt = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            o_fetch_cnt[t*32 +: 32] = fetch_cnt_q[t];
        end
    end
`endif

endmodule

// File: tb/tb_mt_fetch_unit.sv
// tb/tb_mt_fetch_unit.sv - directed self-checking bench for mt_fetch_unit
module tb_mt_fetch_unit;
    import mt_fetch_pkg::*;

    logic        clk;
    logic        rst_n;

    // Two-thread instance
    logic        stall;
    logic [1:0]  thread_en;
    logic        redirect_valid;
    logic [0:0]  redirect_tid;
    logic [25:0] redirect_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic [25:0] pred_target;
    logic        valid;
    logic [25:0] pc_current;
    logic [0:0]  tid_current;
    logic [25:0] pc_next;
    logic [0:0]  tid_next;

    // Single-thread instance for PC wrap
    logic        stall1;
    logic [0:0]  thread_en1;
    logic        valid1;
    logic [25:0] pc_current1;
    logic [0:0]  tid_current1;
    logic [25:0] pc_next1;
    logic [0:0]  tid_next1;

`ifdef MT_FETCH_PERF_EN
    logic [63:0] fetch_cnt;
    logic [31:0] fetch_cnt1;
`endif

    int tests_run;
    int tests_failed;
    int nsteps;
    tid_t tag_tid;

    mt_fetch_unit #(
        .NUM_THREADS  (2),
        .ADDR_WIDTH   (26),
        .RESET_PC     (0),
        .RESET_STRIDE (32'h100)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_stall          (stall),
        .i_thread_en      (thread_en),
        .i_redirect_valid (redirect_valid),
        .i_redirect_tid   (redirect_tid),
        .i_redirect_pc    (redirect_pc),
        .i_pred_valid     (pred_valid),
        .i_pred_taken     (pred_taken),
        .i_pred_target    (pred_target),
        .o_valid          (valid),
        .o_pc_current     (pc_current),
        .o_tid_current    (tid_current),
        .o_pc_next        (pc_next),
        .o_tid_next       (tid_next)
`ifdef MT_FETCH_PERF_EN
        ,
        .o_fetch_cnt      (fetch_cnt)
`endif
    );

    mt_fetch_unit #(
        .NUM_THREADS  (1),
        .ADDR_WIDTH   (26),
        .RESET_PC     (32'h3FFFFFC),
        .RESET_STRIDE (0)
    ) dut1 (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_stall          (stall1),
        .i_thread_en      (thread_en1),
        .i_redirect_valid (1'b0),
        .i_redirect_tid   (1'b0),
        .i_redirect_pc    (26'h0),
        .i_pred_valid     (1'b0),
        .i_pred_taken     (1'b0),
        .i_pred_target    (26'h0),
        .o_valid          (valid1),
        .o_pc_current     (pc_current1),
        .o_tid_current    (tid_current1),
        .o_pc_next        (pc_next1),
        .o_tid_next       (tid_next1)
`ifdef MT_FETCH_PERF_EN
        ,
        .o_fetch_cnt      (fetch_cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle; the single-thread instance stalls after
    // exactly ten unstalled edges so its counter freezes at 10.
    task automatic step();
        @(posedge clk);
        #1;
        nsteps++;
        if (nsteps == 10) stall1 = 1'b1;
    endtask

    task automatic expect_fetch(input string tag, input logic exp_tid, input logic [25:0] exp_pc, input logic exp_valid);
        check({tag, "_tid"},   64'(tid_current), 64'(exp_tid));
        check({tag, "_pc"},    64'(pc_current),  64'(exp_pc));
        check({tag, "_valid"}, 64'(valid),       64'(exp_valid));
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        nsteps         = 0;
        tag_tid        = '0;
        rst_n          = 1'b0;
        stall          = 1'b0;
        thread_en      = 2'b11;
        redirect_valid = 1'b0;
        redirect_tid   = 1'b0;
        redirect_pc    = '0;
        pred_valid     = 1'b0;
        pred_taken     = 1'b0;
        pred_target    = '0;
        stall1         = 1'b0;
        thread_en1     = 1'b1;

        // Reset with a stall and redirect pending: reset must win.
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 26'h0AA;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        #1;
        expect_fetch("reset", 1'b0, 26'h000, 1'b1);
        check("reset_tid_next", 64'(tid_next), 64'd1);
        check("reset_pc_next",  64'(pc_next),  64'h100);
        check("n1_reset_pc",    64'(pc_current1), 64'h3FFFFFC);
        check("n1_reset_pc_next_wrap", 64'(pc_next1), 64'h0);
`ifdef MT_FETCH_PERF_EN
        check("reset_cnt", fetch_cnt, 64'h0);
`endif

        // Round-robin sequence after reset
        step(); expect_fetch("rr1", 1'b1, 26'h100, 1'b1);
        check("n1_wrap_pc", 64'(pc_current1), 64'h0);
        check("n1_tid", 64'(tid_current1), 64'(tag_tid[0]));
        step(); expect_fetch("rr2", 1'b0, 26'h004, 1'b1);
        step(); expect_fetch("rr3", 1'b1, 26'h104, 1'b1);
        step(); expect_fetch("rr4", 1'b0, 26'h008, 1'b1);
        step(); expect_fetch("rr5", 1'b1, 26'h108, 1'b1);
        step(); expect_fetch("rr6", 1'b0, 26'h00C, 1'b1);
        step(); expect_fetch("rr7", 1'b1, 26'h10C, 1'b1);
        step(); expect_fetch("rr8", 1'b0, 26'h010, 1'b1);

        // Taken prediction for thread 0 at 0x010
        pred_valid  = 1'b1;
        pred_taken  = 1'b1;
        pred_target = 26'h080;
        #1;
        check("pred_pc_next", 64'(pc_next), 64'h110);
        step();
        pred_valid = 1'b0;
        pred_taken = 1'b0;
        expect_fetch("pred_t1", 1'b1, 26'h110, 1'b1);
        step(); expect_fetch("pred_t0", 1'b0, 26'h080, 1'b1);

        // Redirect thread 1 together with a taken prediction for thread 0
        redirect_valid = 1'b1;
        redirect_tid   = 1'b1;
        redirect_pc    = 26'h200;
        pred_valid     = 1'b1;
        pred_taken     = 1'b1;
        pred_target    = 26'h300;
        #1;
        check("redir_pc_next",  64'(pc_next),  64'h200);
        check("redir_tid_next", 64'(tid_next), 64'd1);
        step();
        redirect_valid = 1'b0;
        pred_valid     = 1'b0;
        pred_taken     = 1'b0;
        expect_fetch("redir_t1", 1'b1, 26'h200, 1'b1);
        step(); expect_fetch("redir_t0", 1'b0, 26'h300, 1'b1);

        // Stall three cycles with a redirect asserted
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_tid   = 1'b1;
        redirect_pc    = 26'h444;
        #1;
        check("stall_pc_next",  64'(pc_next),  64'h300);
        check("stall_tid_next", 64'(tid_next), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_fetch($sformatf("stall%0d", i), 1'b0, 26'h300, 1'b1);
            check($sformatf("stall%0d_pc_next", i), 64'(pc_next), 64'h300);
        end
        stall          = 1'b0;
        redirect_valid = 1'b0;
        #1;
        check("unstall_pc_next", 64'(pc_next), 64'h204);
        step(); expect_fetch("unstall_t1", 1'b1, 26'h204, 1'b1);
        step(); expect_fetch("unstall_t0", 1'b0, 26'h304, 1'b1);

        // Only thread 0 enabled
        thread_en = 2'b01;
        #1;
        check("en01_tid_next", 64'(tid_next), 64'd0);
        check("en01_pc_next",  64'(pc_next),  64'h308);
        step(); expect_fetch("en01_a", 1'b0, 26'h308, 1'b1);
        step(); expect_fetch("en01_b", 1'b0, 26'h30C, 1'b1);

        // Nothing enabled: one more advance, then idle with PCs held
        thread_en = 2'b00;
        step(); expect_fetch("en00_a", 1'b0, 26'h310, 1'b0);
        check("en00_pc_next", 64'(pc_next), 64'h310);
        step(); expect_fetch("en00_b", 1'b0, 26'h310, 1'b0);

        // Re-enable both: thread 1 resumes where it stopped
        thread_en = 2'b11;
        #1;
        check("en11_tid_next", 64'(tid_next), 64'd1);
        check("en11_pc_next",  64'(pc_next),  64'h208);
        step(); expect_fetch("en11_t1", 1'b1, 26'h208, 1'b1);
        step(); expect_fetch("en11_t0", 1'b0, 26'h310, 1'b1);

        // Single-thread instance has been stalled since its tenth edge
        check("n1_stall_valid", 64'(valid1), 64'd1);
`ifdef MT_FETCH_PERF_EN
        check("n1_cnt", 64'(fetch_cnt1), 64'd10);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mt_fetch_unit.md
MT_FETCH_UNIT -- requirements
Module: mt_fetch_unit

Interface
REQ-001 SHALL have parameter NUM_THREADS, default 2, number of hardware thread contexts (power of two, 1..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 26, byte-address width of every PC.
REQ-003 SHALL have parameter RESET_PC, default 0, reset PC of thread 0.
REQ-004 SHALL have parameter RESET_STRIDE, default 0, reset PC of thread t = RESET_PC + t*RESET_STRIDE, truncated to ADDR_WIDTH.
REQ-005 SHALL have ports, with TW = max(1,$clog2(NUM_THREADS)):
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- i_stall  in  1  global hazard stall
- i_thread_en  in  NUM_THREADS  per-thread schedulable mask
- i_redirect_valid  in  1  PC overwrite request
- i_redirect_tid  in  TW  thread to overwrite
- i_redirect_pc  in  ADDR_WIDTH  new PC
- i_pred_valid  in  1  prediction for current fetch is valid
- i_pred_taken  in  1  predicted taken
- i_pred_target  in  ADDR_WIDTH  predicted target
- o_valid  out  1  current fetch is real
- o_pc_current  out  ADDR_WIDTH  registered PC fetched this cycle
- o_tid_current  out  TW  registered thread of current fetch
- o_pc_next  out  ADDR_WIDTH  combinational PC for next cycle
- o_tid_next  out  TW  combinational thread for next cycle

Function
REQ-006 SHALL hold one PC register per thread, pc[t]; o_pc_current SHALL equal pc[o_tid_current].
REQ-007 Update of current thread c when !i_stall: redirect with tid==c -> i_redirect_pc; else i_pred_valid&i_pred_taken -> i_pred_target; else o_valid -> pc[c]+4 (mod 2^ADDR_WIDTH); else hold.
REQ-008 Redirect to tid!=c when !i_stall SHALL write pc[tid]=i_redirect_pc; prediction applies only to c.
REQ-009 Next thread SHALL be round-robin: first enabled thread scanning c+1, c+2, ... wrapping, c last; NUM_THREADS=1 always selects 0.
REQ-010 No thread enabled SHALL give o_tid_next=c and o_valid=0 next cycle; PCs hold.
REQ-011 o_pc_next SHALL equal the post-update value of pc[o_tid_next], including a same-cycle redirect to o_tid_next.
REQ-012 i_stall=1 SHALL hold all PCs, o_tid_current and o_valid; o_pc_next=o_pc_current, o_tid_next=o_tid_current; redirects and predictions that cycle SHALL be ignored (producer holds them).
REQ-013 Disabled thread SHALL keep its PC, still accept redirects, and resume from it when re-enabled.
REQ-014 Latency: selection and PC update take effect on o_pc_current/o_tid_current one clock edge after the inputs.

Reset
REQ-015 rst_n=0 at clk edge SHALL set pc[t] per REQ-004, o_tid_current=0, o_valid=1, overriding stall, redirect and prediction; reset mid-stream discards all pending state.

Configuration
REQ-016 Macro MT_FETCH_PERF_EN defined SHALL add output o_fetch_cnt (NUM_THREADS x 32 bits), per-thread counter incremented when o_valid&!i_stall for o_tid_current, wrapping at 2^32, reset to 0.
REQ-017 Macro undefined SHALL remove o_fetch_cnt and counters; all other behaviour identical.

Structure
REQ-018 Package mt_fetch_pkg SHALL hold MAX_THREADS=8, tid_t and the PC increment constant 4.
REQ-019 Round-robin selection SHALL be sub-module rr_thread_arbiter (inputs mask and last grant, output next grant and any-valid), purely combinational.

Verification
REQ-020 Reset, N=2, RESET_PC=0, RESET_STRIDE=0x100, both enabled, no stall -> (tid,pc) sequence (0,0x000),(1,0x100),(0,0x004),(1,0x104).
REQ-021 Current tid 0 pc 0x010, pred taken target 0x080 -> thread 0's next fetch is 0x080; thread 1 unaffected.
REQ-022 Redirect tid 1 pc 0x200 together with taken prediction for tid 0 -> both applied; o_pc_next=0x200 same cycle.
REQ-023 i_stall high 3 cycles with redirect asserted -> outputs frozen, redirect ignored, o_pc_next=o_pc_current.
REQ-024 i_thread_en=2'b01 -> only tid 0 fetched, +4 per cycle; then 2'b00 -> o_valid=0, PCs hold; then 2'b11 -> resumes without PC loss.
REQ-025 Thread 0 pc 0x3FFFFFC, N=1 -> wraps to 0x0000000; with MT_FETCH_PERF_EN, counter reads 10 after 10 unstalled valid fetches.
